// File: rtl/move_engine_pkg.sv
// Shared types and constants for the 4x4 sliding-tile game engine.
//   state_t : engine FSM states
//   dir_t   : move direction
//   cell/board geometry, WIN_EXP, and small helpers for cell addressing.
package game_pkg;

   localparam int CELL_W = 4;
   localparam int DIM    = 4;
   localparam int NCELL  = DIM * DIM;
   localparam int GRID_W = NCELL * CELL_W;
   localparam int LINE_W = DIM * CELL_W;

   localparam logic [CELL_W-1:0] WIN_EXP = 4'd11;

   typedef logic [CELL_W-1:0] cell_t;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      SLIDE,
      SPAWN,
      CHECK
   } state_t;

   typedef enum logic [1:0] {
      UP,
      DOWN,
      LEFT,
      RIGHT
   } dir_t;

   // Board cell index {row, col} of element elem within line number line
   // for a move in direction d. Element 0 is always the cell against the
   // target wall.
   function automatic logic [3:0] cell_idx(dir_t d, logic [1:0] line, logic [1:0] elem);
      logic [3:0] idx;
      case (d)
         LEFT:    idx = {line, elem};
         RIGHT:   idx = {line, ~elem};
         UP:      idx = {elem, line};
         default: idx = {~elem, line};
      endcase
      return idx;
   endfunction

   function automatic cell_t get_cell(logic [GRID_W-1:0] g, logic [3:0] idx);
      return g[{idx, 2'b00} +: CELL_W];
   endfunction

   function automatic cell_t sat_inc(cell_t e);
      return (e == 4'hF) ? e : e + 4'd1;
   endfunction

endpackage

// File: rtl/move_engine_if.sv
// Control/status bundle between the button front end / renderer and the
// move engine.
//   master : drives move pulses, new_game, load_en/load_grid; reads status
//   slave  : the engine; drives grid, busy, game_over, win
interface move_engine_if;
    import game_pkg::*;

    logic              btn_up;
    logic              btn_down;
    logic              btn_left;
    logic              btn_right;
    logic              new_game;
    logic              load_en;
    logic [GRID_W-1:0] load_grid;
    logic [GRID_W-1:0] grid;
    logic              busy;
    logic              game_over;
    logic              win;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, new_game, load_en, load_grid,
        input  grid, busy, game_over, win
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, new_game, load_en, load_grid,
        output grid, busy, game_over, win
    );

endinterface

// File: rtl/move_engine_merge_line.sv
// Combinational slide/merge of one 4-cell line toward element 0.
//   line_in  : element i at [4*i +: 4], element 0 at the target wall
//   line_out : compacted and merged line, vacated cells zero
// Each tile merges at most once: [1,1,1,1] -> [2,2,0,0].
module merge_line
    import game_pkg::*;
(
    input  logic [LINE_W-1:0] line_in,
    output logic [LINE_W-1:0] line_out
);

    // comp has a spare always-zero slot so comp[i+1] never falls off the end
    cell_t comp [DIM+1];
    cell_t res  [DIM];

    always_comb begin
        logic [2:0] k;
        logic       skip;

        for (int i = 0; i <= DIM; i++) comp[i] = '0;
        for (int i = 0; i < DIM; i++)  res[i]  = '0;
        line_out = '0;

        k = '0;
        for (int i = 0; i < DIM; i++) begin
            if (line_in[i*CELL_W +: CELL_W] != '0) begin
                comp[k] = line_in[i*CELL_W +: CELL_W];
                k = k + 3'd1;
            end
        end

        k    = '0;
        skip = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[i] != '0) begin
                if (comp[i] == comp[i+1]) begin
                    res[k] = sat_inc(comp[i]);
                    skip   = 1'b1;
                end else begin
                    res[k] = comp[i];
                end
                k = k + 3'd1;
            end
        end

        for (int i = 0; i < DIM; i++) line_out[i*CELL_W +: CELL_W] = res[i];
    end

endmodule

// File: rtl/move_engine.sv
// Game-state engine: owns the 4x4 board, slides one line per cycle on a
// direction pulse, spawns random tiles, and recomputes game_over / win.
//   clk, rst_n : clock, async active-low reset
//   bus        : move_engine_if.slave (pulses/load in; grid/busy/flags out)
//
// state | meaning
// INIT  | post-reset placement of the two starting tiles
// IDLE  | waiting for a move, new_game or load
// SLIDE | processing line line_idx (0..3) of the latched direction
// SPAWN | searching for an empty cell from scan_idx and placing tiles
// CHECK | one cycle recomputing game_over and win
module move_engine
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED        = 16'hACE1,
    parameter logic [3:0]  FOUR_PROB_NIBBLE = 4'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    move_engine_if.slave  bus
);

    state_t            state, state_d;
    dir_t              dir_q, dir_sel;
    logic              dir_valid;
    logic [GRID_W-1:0] grid_q;
    logic [15:0]       lfsr;
    logic [1:0]        line_idx;
    logic              changed;
    logic              changed_next;
    logic [1:0]        spawn_cnt;
    logic [3:0]        scan_idx;
    logic [3:0]        scanned;
    logic              game_over_q;
    logic              win_q;
    logic              busy_o;

    logic [LINE_W-1:0] line_in;
    logic [LINE_W-1:0] line_out;
    logic              cell_empty;
    cell_t             spawn_val;
    logic              board_full;
    logic              has_pair;
    logic              any_win;
    logic              lfsr_fb;

    merge_line u_merge (
        .line_in  (line_in),
        .line_out (line_out)
    );

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        dir_valid = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
        if (bus.btn_up)        dir_sel = UP;
        else if (bus.btn_down) dir_sel = DOWN;
        else if (bus.btn_left) dir_sel = LEFT;
        else                   dir_sel = RIGHT;
    end

    always_comb begin
        line_in = '0;
        for (int e = 0; e < DIM; e++)
            line_in[e*CELL_W +: CELL_W] = get_cell(grid_q, cell_idx(dir_q, line_idx, 2'(e)));
    end

    assign changed_next = changed | (line_out != line_in);
    assign cell_empty   = (get_cell(grid_q, scan_idx) == '0);
    assign spawn_val    = (lfsr[7:4] == FOUR_PROB_NIBBLE) ? 4'd2 : 4'd1;

    // Board status; equal zero pairs are harmless since game_over also needs a full board.
    always_comb begin
        board_full = 1'b1;
        has_pair   = 1'b0;
        any_win    = 1'b0;
        for (int i = 0; i < NCELL; i++) begin
            if (grid_q[i*CELL_W +: CELL_W] == '0)      board_full = 1'b0;
            if (grid_q[i*CELL_W +: CELL_W] >= WIN_EXP) any_win    = 1'b1;
        end
        for (int a = 0; a < DIM; a++) begin
            for (int b = 0; b < DIM - 1; b++) begin
                if (grid_q[(a*DIM + b)*CELL_W +: CELL_W] == grid_q[(a*DIM + b + 1)*CELL_W +: CELL_W])
                    has_pair = 1'b1;
                if (grid_q[(b*DIM + a)*CELL_W +: CELL_W] == grid_q[((b + 1)*DIM + a)*CELL_W +: CELL_W])
                    has_pair = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        if (bus.new_game) begin
            state_d = SPAWN;
        end else if (bus.load_en) begin
            state_d = CHECK;
        end else begin
            case (state)
                IDLE:  if (dir_valid) state_d = SLIDE;
                SLIDE: if (line_idx == 2'd3) state_d = changed_next ? SPAWN : IDLE;
                INIT, SPAWN: begin
                    if (cell_empty) begin
                        if (spawn_cnt == 2'd1) state_d = CHECK;
                    end else if (scanned == 4'd15) begin
                        state_d = CHECK;
                    end
                end
                CHECK:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy_o = (state != IDLE);
    end

    assign bus.busy      = busy_o;
    assign bus.grid      = grid_q;
    assign bus.game_over = game_over_q;
    assign bus.win       = win_q;

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_q      <= '0;
            lfsr        <= LFSR_SEED;
            dir_q       <= UP;
            line_idx    <= '0;
            changed     <= 1'b0;
            spawn_cnt   <= 2'd2;
            scan_idx    <= LFSR_SEED[3:0];
            scanned     <= '0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (bus.new_game) begin
                grid_q      <= '0;
                win_q       <= 1'b0;
                game_over_q <= 1'b0;
                spawn_cnt   <= 2'd2;
                scan_idx    <= lfsr[3:0];
                scanned     <= '0;
            end else if (bus.load_en) begin
                grid_q <= bus.load_grid;
            end else begin
                case (state)
                    IDLE: begin
                        if (dir_valid) begin
                            dir_q    <= dir_sel;
                            line_idx <= '0;
                            changed  <= 1'b0;
                        end
                    end
                    SLIDE: begin
                        for (int e = 0; e < DIM; e++)
                            grid_q[{cell_idx(dir_q, line_idx, 2'(e)), 2'b00} +: CELL_W] <=
                                line_out[e*CELL_W +: CELL_W];
                        changed  <= changed_next;
                        line_idx <= line_idx + 2'd1;
                        if (line_idx == 2'd3 && changed_next) begin
                            spawn_cnt <= 2'd1;
                            scan_idx  <= lfsr[3:0];
                            scanned   <= '0;
                        end
                    end
                    INIT, SPAWN: begin
                        if (cell_empty) begin
                            grid_q[{scan_idx, 2'b00} +: CELL_W] <= spawn_val;
                            spawn_cnt <= spawn_cnt - 2'd1;
                            scan_idx  <= lfsr[3:0];
                            scanned   <= '0;
                        end else begin
                            scan_idx <= scan_idx + 4'd1;
                            scanned  <= scanned + 4'd1;
                        end
                    end
                    CHECK: begin
                        game_over_q <= board_full & ~has_pair;
                        win_q       <= win_q | any_win;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
